// File: rtl/regs_wr_arb_pkg.sv
// Shared register-file bus types, constants and JTAG FSM encodings for the
// write-port arbiter.
package regs_wr_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;  // RegAddrBus
  typedef logic [REG_W-1:0]      reg_word_t;  // RegBus

  localparam reg_addr_t ZERO_REG      = '0;
  localparam reg_word_t ZERO_WORD     = '0;
  localparam logic      WRITE_ENABLE  = 1'b1;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam logic      RST_ENABLE    = 1'b1;

  typedef enum logic [1:0] {
    JTAG_IDLE = 2'd0,
    JTAG_PEND = 2'd1,
    JTAG_DONE = 2'd2
  } jtag_state_t;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_word_t data;
  } wr_port_t;

  // Writes to register 0 are acknowledged but never reach the register file.
  function automatic logic writes_reg(input reg_addr_t addr);
    return (addr != ZERO_REG) ? WRITE_ENABLE : WRITE_DISABLE;
  endfunction

endpackage

// File: rtl/regs_wr_arb_if.sv
// Signal bundle between the write sources (EX, divider, JTAG) and the
// register-file write-port arbiter.
interface regs_wr_arb_if;
  import regs_wr_arb_pkg::*;

  // Handshakes: EX is a plain per-cycle strobe and is never back-pressured.
  // div_req_i is a level held with stable addr/data until div_ack_o pulses for
  // the one cycle the write is issued. jtag_req_i is four-phase: raise req,
  // wait for jtag_ack_o, drop req, wait for jtag_ack_o to drop.
  logic        ex_we_i;
  reg_addr_t   ex_waddr_i;
  reg_word_t   ex_wdata_i;

  logic        div_req_i;
  reg_addr_t   div_waddr_i;
  reg_word_t   div_wdata_i;
  logic        div_ack_o;

  logic        jtag_req_i;
  reg_addr_t   jtag_waddr_i;
  reg_word_t   jtag_wdata_i;
  logic        jtag_ack_o;

  logic        hold_ex_o;

  logic        we_o;
  reg_addr_t   waddr_o;
  reg_word_t   wdata_o;

  jtag_state_t jtag_state;

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output div_req_i, div_waddr_i, div_wdata_i,
    output jtag_req_i, jtag_waddr_i, jtag_wdata_i,
    input  div_ack_o, jtag_ack_o, hold_ex_o,
    input  we_o, waddr_o, wdata_o,
    input  jtag_state
  );

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  div_req_i, div_waddr_i, div_wdata_i,
    input  jtag_req_i, jtag_waddr_i, jtag_wdata_i,
    output div_ack_o, jtag_ack_o, hold_ex_o,
    output we_o, waddr_o, wdata_o,
    output jtag_state
  );

endinterface

// File: rtl/regs_wr_arb.sv
// Register-file write-port arbiter: EX > divider > JTAG, zero-latency write
// port, with a starvation guard that holds the core for a waiting JTAG write.
module regs_wr_arb
  import regs_wr_arb_pkg::*;
#(
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rst,
  regs_wr_arb_if.slave  bus
);

  localparam int               CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  jtag_state_t      state_q, state_d;
  reg_addr_t        jtag_addr_q;
  reg_word_t        jtag_data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;
  logic             ack_q, ack_d;
  logic             capture;
  logic             jtag_grant;
  logic             div_grant;
  wr_port_t         wr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) state_q <= JTAG_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      JTAG_IDLE: if (bus.jtag_req_i)  state_d = JTAG_PEND;
      JTAG_PEND: if (jtag_grant)      state_d = JTAG_DONE;
      JTAG_DONE: if (!bus.jtag_req_i) state_d = JTAG_IDLE;
      default:                        state_d = JTAG_IDLE;
    endcase
  end

  // FSM outputs: capture strobe, grant, starvation counter and hold request.
  // The counter only advances while a latched write is refused, and hold is
  // raised one cycle after it saturates, staying up until the grant edge.
  always_comb begin
    capture    = 1'b0;
    jtag_grant = 1'b0;
    cnt_d      = '0;
    hold_d     = 1'b0;
    ack_d      = (state_d == JTAG_DONE);
    case (state_q)
      JTAG_IDLE: capture = bus.jtag_req_i;
      JTAG_PEND: begin
        jtag_grant = !bus.ex_we_i && !bus.div_req_i;
        if (!jtag_grant) begin
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          hold_d = (cnt_q == CNT_MAX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      jtag_addr_q <= ZERO_REG;
      jtag_data_q <= ZERO_WORD;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      if (capture) begin
        jtag_addr_q <= bus.jtag_waddr_i;
        jtag_data_q <= bus.jtag_wdata_i;
      end
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      ack_q  <= ack_d;
    end
  end

  // Write-port mux; combinational so the register-file bypass sees EX data.
  always_comb begin
    div_grant = 1'b0;
    wr        = '{we: WRITE_DISABLE, addr: ZERO_REG, data: ZERO_WORD};
    if (rst != RST_ENABLE) begin
      if (bus.ex_we_i) begin
        wr = '{we: WRITE_ENABLE, addr: bus.ex_waddr_i, data: bus.ex_wdata_i};
      end else if (bus.div_req_i) begin
        div_grant = 1'b1;
        wr = '{we:   writes_reg(bus.div_waddr_i),
               addr: bus.div_waddr_i,
               data: bus.div_wdata_i};
      end else if (jtag_grant) begin
        wr = '{we: writes_reg(jtag_addr_q), addr: jtag_addr_q, data: jtag_data_q};
      end
    end
  end

  assign bus.we_o       = wr.we;
  assign bus.waddr_o    = wr.addr;
  assign bus.wdata_o    = wr.data;
  assign bus.div_ack_o  = div_grant;
  assign bus.jtag_ack_o = ack_q;
  assign bus.hold_ex_o  = hold_q;
  assign bus.jtag_state = state_q;

endmodule
